left_leds_pattern_engine: RTL and testbench

- Downstream consumer of the left_leds AXI4-Lite register slave.
- Takes the slave's four programmed register values (control, pattern, period, duty) plus a load strobe, and drives the board LEDs.
- Modes: static, blink, rotate or bounce, each with a PWM brightness overlay.
- Pure fabric logic on the AXI clock; no bus interface of its own.

---
 rtl/left_leds_pkg.sv | 23 ++
 rtl/left_leds_pwm.sv | 30 +++
 rtl/left_leds_pattern_engine.sv | 148 ++++++++++++++
 tb/tb_left_leds_pattern_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/left_leds_pkg.sv
// Shared types and constants for the left_leds pattern engine
// and the AXI4-Lite register slave that programs it.
package left_leds_pkg;

    typedef enum logic [1:0] {
        LED_STATIC = 2'd0,
        LED_BLINK  = 2'd1,
        LED_ROTATE = 2'd2,
        LED_BOUNCE = 2'd3
    } led_mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } led_dir_e;

    localparam int STEP_CNT_W = 16;

    // control register layout, shared with the register slave
    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;

endpackage

// File: rtl/left_leds_pwm.sv
// Free-running PWM counter plus duty compare.
// Ports: i_clk/i_rst clock and async reset, i_en count enable,
//        i_clr synchronous restart, i_duty brightness, o_pwm_on.
module left_leds_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm_on
);

    logic [PWM_BITS-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + PWM_BITS'(1);
        end
    end

    // all-ones duty must be solidly on, which the compare alone cannot give
    assign o_pwm_on = (&i_duty) | (r_cnt < i_duty);

endmodule

// File: rtl/left_leds_pattern_engine.sv
// LED pattern engine: shadowed config, step prescaler, pattern
// stepping (static/blink/rotate/bounce) and a PWM brightness overlay.
// Ports: ACLK, ARESET (async high); cfg_enable live run enable;
//        cfg_mode/pattern/period/duty latched on cfg_load;
//        leds registered drive, tick_o step pulse, step_cnt steps.
module left_leds_pattern_engine
    import left_leds_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int PWM_BITS  = 8,
    parameter int DIV_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_mode,
    input  logic [NUM_LEDS-1:0]   cfg_pattern,
    input  logic [DIV_WIDTH-1:0]  cfg_period,
    input  logic [PWM_BITS-1:0]   cfg_duty,
    input  logic                  cfg_load,
    output logic [NUM_LEDS-1:0]   leds,
    output logic                  tick_o,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    led_mode_e              r_mode;
    logic [NUM_LEDS-1:0]    r_pattern;
    logic [DIV_WIDTH-1:0]   r_period;
    logic [PWM_BITS-1:0]    r_duty;
    logic [NUM_LEDS-1:0]    r_frame;
    logic [DIV_WIDTH-1:0]   r_presc;
    logic                   r_phase;
    led_dir_e               r_dir;
    logic [STEP_CNT_W-1:0]  r_step;
    logic                   r_tick;
    logic [NUM_LEDS-1:0]    r_leds;

    logic                   w_pwm_on;
    logic                   w_tick_nxt;
    logic [NUM_LEDS-1:0]    w_frame_nxt;
    logic                   w_phase_nxt;
    led_dir_e               w_dir_nxt;
    logic [NUM_LEDS-1:0]    w_shl;
    logic [NUM_LEDS-1:0]    w_shr;
    logic [NUM_LEDS-1:0]    w_rol;

    left_leds_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .i_clk    (ACLK),
        .i_rst    (ARESET),
        .i_en     (cfg_enable),
        .i_clr    (cfg_load),
        .i_duty   (r_duty),
        .o_pwm_on (w_pwm_on)
    );

    assign w_tick_nxt = (r_presc == r_period);
    assign w_shl      = {r_frame[NUM_LEDS-2:0], 1'b0};
    assign w_shr      = {1'b0, r_frame[NUM_LEDS-1:1]};
    assign w_rol      = {r_frame[NUM_LEDS-2:0], r_frame[NUM_LEDS-1]};

    // next frame, applied only on the cycle tick_o is high
    always_comb begin
        w_frame_nxt = r_frame;
        w_phase_nxt = r_phase;
        w_dir_nxt   = r_dir;
        unique case (r_mode)
            LED_STATIC: begin
            end
            LED_BLINK: begin
                w_phase_nxt = ~r_phase;
                w_frame_nxt = w_phase_nxt ? '0 : r_pattern;
            end
            LED_ROTATE: begin
                w_frame_nxt = w_rol;
            end
            LED_BOUNCE: begin
                // hitting an edge reverses and moves back in the same step
                if (r_dir == DIR_LEFT) begin
                    if (r_frame[NUM_LEDS-1]) begin
                        w_dir_nxt   = DIR_RIGHT;
                        w_frame_nxt = w_shr;
                    end else begin
                        w_frame_nxt = w_shl;
                    end
                end else begin
                    if (r_frame[0]) begin
                        w_dir_nxt   = DIR_LEFT;
                        w_frame_nxt = w_shl;
                    end else begin
                        w_frame_nxt = w_shr;
                    end
                end
                if (w_frame_nxt == '0) begin
                    w_frame_nxt = r_pattern;
                    w_dir_nxt   = DIR_LEFT;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_mode    <= LED_STATIC;
            r_pattern <= '0;
            r_period  <= '0;
            r_duty    <= '0;
            r_frame   <= '0;
            r_presc   <= '0;
            r_phase   <= 1'b0;
            r_dir     <= DIR_LEFT;
            r_step    <= '0;
            r_tick    <= 1'b0;
            r_leds    <= '0;
        end else begin
            r_leds <= cfg_enable ? (r_frame & {NUM_LEDS{w_pwm_on}}) : '0;
            if (cfg_load) begin
                r_mode    <= led_mode_e'(cfg_mode);
                r_pattern <= cfg_pattern;
                r_period  <= cfg_period;
                r_duty    <= cfg_duty;
                r_frame   <= cfg_pattern;
                r_presc   <= '0;
                r_phase   <= 1'b0;
                r_dir     <= DIR_LEFT;
                r_step    <= '0;
                r_tick    <= 1'b0;
            end else if (cfg_enable) begin
                r_presc <= w_tick_nxt ? '0 : r_presc + DIV_WIDTH'(1);
                r_tick  <= w_tick_nxt;
                if (r_tick) begin
                    r_frame <= w_frame_nxt;
                    r_phase <= w_phase_nxt;
                    r_dir   <= w_dir_nxt;
                    r_step  <= r_step + STEP_CNT_W'(1);
                end
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign leds     = r_leds;
    assign tick_o   = r_tick;
    assign step_cnt = r_step;

endmodule

// File: tb/tb_left_leds_pattern_engine.sv
// Randomized bench for left_leds_pattern_engine against an
// integer reference model, plus directed rotate and PWM checks.
module tb_left_leds_pattern_engine;

    logic        ACLK;
    logic        ARESET;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  pat;
    logic [31:0] per;
    logic [7:0]  duty;
    logic        load;
    logic [3:0]  leds;
    logic        tick_o;
    logic [15:0] step_cnt;

    int n_chk;
    int n_fail;

    // reference model state, plain integers
    int m_mode, m_pat, m_duty, m_frame, m_pwm;
    int m_phase, m_right, m_step, m_tick, m_leds;
    longint m_per, m_presc;

    left_leds_pattern_engine dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cfg_enable  (en),
        .cfg_mode    (mode),
        .cfg_pattern (pat),
        .cfg_period  (per),
        .cfg_duty    (duty),
        .cfg_load    (load),
        .leds        (leds),
        .tick_o      (tick_o),
        .step_cnt    (step_cnt)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pat = 0; m_per = 0; m_duty = 0;
        m_frame = 0; m_presc = 0; m_pwm = 0; m_phase = 0;
        m_right = 0; m_step = 0; m_tick = 0; m_leds = 0;
    endtask

    // one pattern step, from the mode rules
    task automatic model_step();
        int f;
        case (m_mode)
            1: begin
                m_phase = 1 - m_phase;
                m_frame = (m_phase == 1) ? 0 : m_pat;
            end
            2: m_frame = ((m_frame * 2) % 16) + (m_frame / 8);
            3: begin
                if (m_right == 0) begin
                    if (m_frame >= 8) begin
                        m_right = 1;
                        f = m_frame / 2;
                    end else f = (m_frame * 2) % 16;
                end else begin
                    if (m_frame % 2 == 1) begin
                        m_right = 0;
                        f = (m_frame * 2) % 16;
                    end else f = m_frame / 2;
                end
                if (f == 0) begin
                    f = m_pat;
                    m_right = 0;
                end
                m_frame = f;
            end
            default: ;
        endcase
        m_step = (m_step + 1) % 65536;
    endtask

    task automatic model_clk();
        int on;
        int nleds;
        int tick_n;
        on = (m_duty == 255 || m_pwm < m_duty) ? 1 : 0;
        nleds = (en && on == 1) ? m_frame : 0;
        if (load) begin
            m_mode = int'(mode); m_pat = int'(pat);
            m_per = longint'(per); m_duty = int'(duty);
            m_frame = int'(pat); m_presc = 0; m_pwm = 0;
            m_phase = 0; m_right = 0; m_step = 0; m_tick = 0;
        end else if (en) begin
            tick_n = (m_presc == m_per) ? 1 : 0;
            if (m_tick == 1) model_step();
            m_presc = (tick_n == 1) ? 0 : m_presc + 1;
            m_tick = tick_n;
            m_pwm = (m_pwm + 1) % 256;
        end else begin
            m_tick = 0;
        end
        m_leds = nleds;
    endtask

    task automatic cmp_all();
        chk("leds", {28'd0, leds}, m_leds);
        chk("tick", {31'd0, tick_o}, m_tick);
        chk("step", {16'd0, step_cnt}, m_step);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            model_clk();
            #1;
            cmp_all();
        end
    endtask

    task automatic do_load(input logic [1:0] md, input logic [3:0] p,
                           input logic [31:0] pr, input logic [7:0] d);
        mode = md; pat = p; per = pr; duty = d;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 ARESET = 1'b1;
        #1;
        model_reset();
        chk("rst_async_leds", {28'd0, leds}, 32'd0);
        chk("rst_async_tick", {31'd0, tick_o}, 32'd0);
        chk("rst_async_step", {16'd0, step_cnt}, 32'd0);
        @(posedge ACLK);
        #1;
        cmp_all();
        #3 ARESET = 1'b0;
    endtask

    initial begin
        int vals[$];
        int times[$];
        int prev;
        int ones;
        bit found;
        logic [7:0] dsel;

        n_chk = 0; n_fail = 0;
        ARESET = 1'b1; en = 1'b0; mode = '0; pat = '0;
        per = '0; duty = '0; load = 1'b0;
        model_reset();
        #12;
        cmp_all();
        @(negedge ACLK);
        ARESET = 1'b0;
        en = 1'b1;
        cyc(4);

        // static
        do_load(2'd0, 4'b1010, 32'd2, 8'hFF);
        cyc(30);

        // rotate with explicit sequence and spacing
        do_load(2'd2, 4'b0001, 32'd3, 8'hFF);
        prev = -1;
        for (int c = 1; c <= 20; c++) begin
            cyc(1);
            if (int'(leds) != prev) begin
                vals.push_back(int'(leds));
                times.push_back(c);
                prev = int'(leds);
            end
        end
        chk("rot_nchg", vals.size(), 5);
        if (vals.size() >= 5) begin
            chk("rot_v0", vals[0], 1);
            chk("rot_v1", vals[1], 2);
            chk("rot_v2", vals[2], 4);
            chk("rot_v3", vals[3], 8);
            chk("rot_v4", vals[4], 1);
            for (int i = 2; i <= 4; i++)
                chk("rot_gap", times[i] - times[i-1], 4);
        end

        // bounce, then empty pattern
        do_load(2'd3, 4'b0001, 32'd0, 8'hFF);
        cyc(20);
        do_load(2'd3, 4'b0000, 32'd0, 8'hFF);
        cyc(10);

        // PWM duty count over one full PWM period
        do_load(2'd0, 4'b1010, 32'hFFFF_FFFF, 8'h40);
        cyc(2);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (leds == 4'b1010) ones++;
        end
        chk("pwm_ones", ones, 64);

        // blink with PWM, then duty 0
        do_load(2'd1, 4'b1111, 32'd9, 8'h40);
        cyc(300);
        do_load(2'd1, 4'b1111, 32'd9, 8'h00);
        cyc(40);

        // enable hold mid-rotation
        do_load(2'd2, 4'b0001, 32'd5, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc(1);
            if (leds == 4'b0100) found = 1'b1;
        end
        chk("wait_0100", {31'd0, found}, 32'd1);
        en = 1'b0;
        cyc(7);
        en = 1'b1;
        cyc(30);

        // load colliding with a tick
        do_load(2'd2, 4'b0001, 32'd2, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1);
            if (tick_o) found = 1'b1;
        end
        chk("wait_tick", {31'd0, found}, 32'd1);
        do_load(2'd2, 4'b1000, 32'd2, 8'hFF);
        chk("coll_step", {16'd0, step_cnt}, 32'd0);
        cyc(2);
        chk("coll_leds", {28'd0, leds}, 32'd8);

        // reset mid-run, outputs stay dark until reloaded
        cyc(5);
        pulse_reset();
        cyc(20);
        chk("post_rst_leds", {28'd0, leds}, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 2))
                    0: dsel = 8'h00;
                    1: dsel = 8'hFF;
                    default: dsel = 8'($urandom);
                endcase
                do_load(2'($urandom), 4'($urandom),
                        32'($urandom_range(0, 6)), dsel);
            end else begin
                if ($urandom_range(0, 39) == 0) en = ~en;
                if ($urandom_range(0, 499) == 0) pulse_reset();
                cyc(1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
